stream_id_fifo_router: RTL



---
 rtl/stream_id_fifo_router_if.sv | 37 +++
 rtl/stream_id_fifo_router.sv | 114 +++++++++++
 2 files changed

// File: rtl/stream_id_fifo_router_if.sv
// Request/response stream bundle between a crossbar output, the ID-FIFO router and its target.
// The master side drives the router inputs; the slave modport is the router's view.
interface stream_id_fifo_router_if #(
  parameter int unsigned NumInp   = 32'd2,
  parameter int unsigned ReqWidth = 32'd32,
  parameter int unsigned RspWidth = 32'd32
);
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;

  logic [ReqWidth-1:0]              req_data_i;
  logic [IdxWidth-1:0]              req_idx_i;
  logic                             req_valid_i;
  logic                             req_ready_o;
  logic [ReqWidth-1:0]              req_data_o;
  logic                             req_valid_o;
  logic                             req_ready_i;
  logic [RspWidth-1:0]              rsp_data_i;
  logic                             rsp_valid_i;
  logic                             rsp_ready_o;
  logic [NumInp-1:0][RspWidth-1:0]  rsp_data_o;
  logic [NumInp-1:0]                rsp_valid_o;
  logic [NumInp-1:0]                rsp_ready_i;

  modport master (
    output req_data_i, req_idx_i, req_valid_i, req_ready_i,
           rsp_data_i, rsp_valid_i, rsp_ready_i,
    input  req_ready_o, req_data_o, req_valid_o,
           rsp_ready_o, rsp_data_o, rsp_valid_o
  );

  modport slave (
    input  req_data_i, req_idx_i, req_valid_i, req_ready_i,
           rsp_data_i, rsp_valid_i, rsp_ready_i,
    output req_ready_o, req_data_o, req_valid_o,
           rsp_ready_o, rsp_data_o, rsp_valid_o
  );
endinterface

// File: rtl/stream_id_fifo_router.sv
// Forwards requests to one in-order target and steers its responses back to the source input
// recorded in an ID FIFO. Optional sticky err_o is enabled by defining STREAM_ID_FIFO_ERR_EN.
module stream_id_fifo_router #(
  parameter int unsigned NumInp   = 32'd2,
  parameter int unsigned ReqWidth = 32'd32,
  parameter int unsigned RspWidth = 32'd32,
  parameter int unsigned Depth    = 32'd4
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  stream_id_fifo_router_if.slave      bus,
  output logic [$clog2(Depth+1)-1:0]  outstanding_o
`ifdef STREAM_ID_FIFO_ERR_EN
  ,
  output logic                        err_o
`endif
);
  localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1;
  localparam int unsigned CntWidth = $clog2(Depth + 1);
  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);
  localparam logic [CntWidth-1:0] FullCnt = CntWidth'(Depth);

  logic [IdxWidth-1:0] r_fifo [Depth];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [CntWidth-1:0] r_count;

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [IdxWidth-1:0] w_head;
  logic                w_head_ready;
  logic                w_rsp_ready;

  assign w_full  = (r_count == FullCnt);
  assign w_empty = (r_count == '0);
  assign w_head  = r_fifo[r_rd_ptr];

  // Request side depends only on the registered count, never on the response handshake.
  assign bus.req_data_o  = bus.req_data_i;
  assign bus.req_valid_o = bus.req_valid_i & ~w_full;
  assign bus.req_ready_o = bus.req_ready_i & ~w_full;
  assign w_push          = bus.req_valid_i & bus.req_ready_i & ~w_full;

  always_comb begin
    bus.rsp_valid_o = '0;
    bus.rsp_data_o  = '0;
    w_head_ready    = 1'b0;
    for (int k = 0; k < NumInp; k++) begin
      bus.rsp_data_o[k] = bus.rsp_data_i;
      if (w_head == IdxWidth'(k)) begin
        bus.rsp_valid_o[k] = bus.rsp_valid_i & ~w_empty;
        w_head_ready       = bus.rsp_ready_i[k];
      end
    end
  end

  assign w_rsp_ready     = ~w_empty & w_head_ready;
  assign bus.rsp_ready_o = w_rsp_ready;
  assign w_pop           = bus.rsp_valid_i & w_rsp_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + PtrWidth'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + PtrWidth'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntWidth'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntWidth'(1);
      end
    end
  end

  // Entry contents need no reset: occupancy alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) begin
      r_fifo[r_wr_ptr] <= bus.req_idx_i;
    end
  end

  assign outstanding_o = r_count;

`ifdef STREAM_ID_FIFO_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_err <= 1'b0;
    end else if (flush_i) begin
      r_err <= 1'b0;
    end else if ((bus.rsp_valid_i && w_empty) ||
                 (w_push && (32'(bus.req_idx_i) >= NumInp))) begin
      r_err <= 1'b1;
    end
  end

  assign err_o = r_err;
`endif
endmodule
